hot_page_dump_ctrl: RTL
=======================

HOT_PAGE_DUMP_CTRL -- requirements
Module: hot_page_dump_ctrl

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 28, the tracked page address width.
REQ-002 SHALL have parameter CNT_SIZE, default 32, the CAM counter width.
REQ-003 SHALL have parameter NUM_ENTRY, default 25, the sorted CAM depth; INDEX_SIZE = $clog2(NUM_ENTRY).
REQ-004 SHALL have parameter EPOCH_CYCLES, default 450000, the RUN cycles per epoch (1 ms at 450 MHz).
REQ-005 SHALL have parameter DRAIN_CYCLES, default 8, the wait cycles for the sketch/CAM pipeline to empty.
REQ-006 SHALL have ports: clk in 1 clock; rst_n in 1 asynchronous active-low reset; one clock domain only.
REQ-007 SHALL have ports: in_valid in 1, in_ready out 1, in_addr in ADDR_SIZE; this is the upstream access stream.
REQ-008 SHALL have ports: cms_valid out 1 and cms_addr out ADDR_SIZE, which drive the sketch+CAM datapath input.
REQ-009 SHALL have ports: dump_trigger in 1 (forces an early epoch end) and rd_idx out INDEX_SIZE (CAM entry read index).
REQ-010 SHALL have ports: rd_cnt in CNT_SIZE and rd_addr in ADDR_SIZE, the CAM entry contents valid 1 cycle after rd_idx.
REQ-011 SHALL have ports: out_valid out 1, out_ready in 1, out_addr out ADDR_SIZE, out_cnt out CNT_SIZE, out_last out 1, forming the dump stream.
REQ-012 SHALL have ports: clr out 1 (datapath clear pulse) and epoch_id out 16 (completed-epoch count).

Function
REQ-013 SHALL implement the states RUN, DRAIN, READ, OUT and CLEAR.
REQ-014 SHALL drive in_ready = (state==RUN), combinationally.
REQ-015 SHALL register cms_valid <= in_valid&&in_ready and cms_addr <= in_addr, giving 1-cycle latency; cms_addr holds its value when idle.
REQ-016 SHALL, in RUN, increment the epoch counter each cycle; when the counter equals EPOCH_CYCLES-1 or dump_trigger is 1, go to DRAIN, clear the counter and clear the drain counter.
REQ-017 SHALL forward an access accepted in the same cycle as the RUN->DRAIN transition normally, so it belongs to the closing epoch.
REQ-018 SHALL ignore dump_trigger outside RUN, with no queuing.
REQ-019 SHALL, in DRAIN, count DRAIN_CYCLES cycles, then go to READ with idx=0.
REQ-020 SHALL, in READ, hold rd_idx=idx for 1 cycle, then capture rd_addr/rd_cnt into out_addr/out_cnt, set out_valid=1 and out_last=(idx==NUM_ENTRY-1), and go to OUT.
REQ-021 SHALL, in OUT, hold out_* stable while out_ready=0; on out_ready=1, clear out_valid and then go to READ with idx+1, or if out_last go to CLEAR.
REQ-022 SHALL emit exactly NUM_ENTRY beats per epoch, in CAM order, including zero-count entries.
REQ-023 SHALL, in CLEAR, assert clr for exactly 1 cycle, increment epoch_id (wrapping modulo 2^16), and return to RUN.
REQ-024 SHALL otherwise hold rd_idx at 0 outside READ.

Reset
REQ-025 SHALL, on rst_n low, asynchronously set state=RUN and set epoch counter, drain counter, idx, cms_valid, cms_addr, out_valid, out_addr, out_cnt, out_last, clr and epoch_id to 0.
REQ-026 SHALL abandon an in-progress dump on reset mid-dump, with no clr issued; the next epoch starts from 0.

Configuration
REQ-027 SHALL support macro HOT_DUMP_CLEAR_EN: when defined, CLEAR behaves as in REQ-023; when undefined, the CLEAR state is skipped (OUT with out_last goes directly to RUN), clr is tied 0, epoch_id still increments, and counts accumulate across epochs.

Structure
REQ-028 SHALL place the state enum typedef and the default parameter constants in package hot_dump_pkg.
REQ-029 SHALL place the epoch counter plus its terminal/trigger compare in sub-module hot_dump_epoch_timer (ports clk, rst_n, run, trigger, expire).

Verification (bench params EPOCH_CYCLES=100, DRAIN_CYCLES=8, NUM_ENTRY=25)
REQ-030 SHALL cover back-to-back in_valid=1 from reset: cms_valid goes high 1 cycle later; in_ready drops exactly at cycle 100 of RUN; exactly 100 accesses are forwarded.
REQ-031 SHALL cover out_ready held 1 with rd model returning cnt=25-idx, addr=0x1000+idx: 25 beats with out_cnt 25..1, out_last only on beat 25, clr pulse once, epoch_id=1.
REQ-032 SHALL cover out_ready toggling randomly at 30%: out_* stays stable while stalled, no beat is lost or duplicated, and the sequence is identical to REQ-031.
REQ-033 SHALL cover dump_trigger pulsed at RUN cycle 10 and again during OUT: the first gives an early dump; the second is ignored; the epoch counter restarts at 0 after CLEAR.
REQ-034 SHALL cover rst_n asserted during OUT beat 12: all outputs are 0 immediately, there is no clr, and the next dump starts at idx 0 after 100 cycles.
REQ-035 SHALL cover a build without HOT_DUMP_CLEAR_EN: clr is never 1, RUN resumes the cycle after the last handshake, and epoch_id still increments.

Source files
------------

// File: rtl/hot_dump_pkg.sv
// Shared state encoding and default build constants for the hot-page dump controller.
package hot_dump_pkg;

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        DRAIN = 3'd1,
        READ  = 3'd2,
        OUT   = 3'd3,
        CLEAR = 3'd4
    } dump_state_t;

    localparam int ADDR_SIZE_DEF    = 28;
    localparam int CNT_SIZE_DEF     = 32;
    localparam int NUM_ENTRY_DEF    = 25;
    localparam int EPOCH_CYCLES_DEF = 450000;
    localparam int DRAIN_CYCLES_DEF = 8;

endpackage

// File: rtl/hot_dump_epoch_timer.sv
// Epoch length counter: expires on the last RUN cycle of an epoch or on an early trigger.
module hot_dump_epoch_timer #(
    parameter int EPOCH_CYCLES = 450000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic trigger,
    output logic expire
);

    localparam int TW = $clog2(EPOCH_CYCLES + 1);
    localparam logic [TW-1:0] LAST_CNT = TW'(EPOCH_CYCLES - 1);

    logic [TW-1:0] cnt;

    assign expire = run && ((cnt == LAST_CNT) || trigger);

    // Counter is zeroed on expiry, so it waits at 0 through the dump.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (expire)
            cnt <= '0;
        else if (run)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/hot_page_dump_ctrl.sv
// Epoch controller: forwards accesses to the sketch/CAM, then streams every CAM entry out.
// Define HOT_DUMP_CLEAR_EN to clear the datapath after each dump; otherwise counts accumulate.
import hot_dump_pkg::*;

module hot_page_dump_ctrl #(
    parameter int ADDR_SIZE    = ADDR_SIZE_DEF,
    parameter int CNT_SIZE     = CNT_SIZE_DEF,
    parameter int NUM_ENTRY    = NUM_ENTRY_DEF,
    parameter int EPOCH_CYCLES = EPOCH_CYCLES_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_SIZE-1:0]         in_addr,
    output logic                         cms_valid,
    output logic [ADDR_SIZE-1:0]         cms_addr,
    input  logic                         dump_trigger,
    output logic [$clog2(NUM_ENTRY)-1:0] rd_idx,
    input  logic [CNT_SIZE-1:0]          rd_cnt,
    input  logic [ADDR_SIZE-1:0]         rd_addr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ADDR_SIZE-1:0]         out_addr,
    output logic [CNT_SIZE-1:0]          out_cnt,
    output logic                         out_last,
    output logic                         clr,
    output logic [15:0]                  epoch_id
);

    localparam int INDEX_SIZE = $clog2(NUM_ENTRY);
    localparam int DW         = $clog2(DRAIN_CYCLES + 1);
    localparam logic [INDEX_SIZE-1:0] LAST_IDX   = INDEX_SIZE'(NUM_ENTRY - 1);
    localparam logic [DW-1:0]         LAST_DRAIN = DW'(DRAIN_CYCLES - 1);

`ifdef HOT_DUMP_CLEAR_EN
    localparam dump_state_t DONE_ST = CLEAR;
`else
    localparam dump_state_t DONE_ST = RUN;
`endif

    dump_state_t           state_q, state_d;
    logic [DW-1:0]         dcnt;
    logic [INDEX_SIZE-1:0] idx;
    logic                  rd_wait;
    logic                  expire;

    assign in_ready = (state_q == RUN);
    assign rd_idx   = (state_q == READ) ? idx : '0;

`ifdef HOT_DUMP_CLEAR_EN
    assign clr = (state_q == CLEAR);
`else
    assign clr = 1'b0;
`endif

    hot_dump_epoch_timer #(.EPOCH_CYCLES(EPOCH_CYCLES)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (in_ready),
        .trigger (dump_trigger),
        .expire  (expire)
    );

    // An access accepted on the expiring cycle still belongs to the closing epoch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cms_valid <= 1'b0;
            cms_addr  <= '0;
        end else begin
            cms_valid <= in_valid && in_ready;
            if (in_valid && in_ready)
                cms_addr <= in_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (expire) state_d = DRAIN;
            DRAIN:   if (dcnt == LAST_DRAIN) state_d = READ;
            READ:    if (rd_wait) state_d = OUT;
            OUT:     if (out_ready) state_d = out_last ? DONE_ST : READ;
            CLEAR:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // READ spends one cycle presenting rd_idx and one with the CAM data valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt      <= '0;
            idx       <= '0;
            rd_wait   <= 1'b0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_cnt   <= '0;
            out_last  <= 1'b0;
            epoch_id  <= '0;
        end else begin
            case (state_q)
                RUN: if (expire) dcnt <= '0;
                DRAIN: begin
                    if (dcnt == LAST_DRAIN) begin
                        idx     <= '0;
                        rd_wait <= 1'b0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                READ: begin
                    if (!rd_wait) begin
                        rd_wait <= 1'b1;
                    end else begin
                        rd_wait   <= 1'b0;
                        out_valid <= 1'b1;
                        out_addr  <= rd_addr;
                        out_cnt   <= rd_cnt;
                        out_last  <= (idx == LAST_IDX);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (!out_last)
                            idx <= idx + 1'b1;
`ifndef HOT_DUMP_CLEAR_EN
                        else
                            epoch_id <= epoch_id + 1'b1;
`endif
                    end
                end
                CLEAR: epoch_id <= epoch_id + 1'b1;
                default: ;
            endcase
        end
    end

endmodule
